// File: rtl/program_loader_pkg.sv
// Shared CPU definitions for the boot-time program loader: frame constants and FSM state codes.
package program_loader_pkg;

    localparam logic [7:0] START_BYTE = 8'hA5;
    localparam int         MAX_WORDS  = 4096;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_LEN_HI  = 4'd1;
    localparam logic [3:0] ST_LEN_LO  = 4'd2;
    localparam logic [3:0] ST_DATA_HI = 4'd3;
    localparam logic [3:0] ST_DATA_LO = 4'd4;
    localparam logic [3:0] ST_WRITE   = 4'd5;
    localparam logic [3:0] ST_CHECK   = 4'd6;
    localparam logic [3:0] ST_DONE    = 4'd7;
    localparam logic [3:0] ST_ERROR   = 4'd8;

endpackage

// File: rtl/program_loader.sv
// Receives a framed byte stream (A5, len_hi, len_lo, words..., xor checksum), writes the
// words into instruction memory and releases the CPU only once the checksum verifies.
module program_loader
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [11:0] imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_enable,
    output logic        load_done,
    output logic        load_error,
    output logic [3:0]  fsm_state
);

    localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

    // Handshake: a byte moves only on a rising edge where rx_valid && rx_ready;
    // rx_ready is low solely in the WRITE cycle, so a held rx_valid simply stalls one cycle.
    logic [3:0]  state;
    logic [15:0] word_count;
    logic [11:0] word_index;
    logic [7:0]  data_hi;
    logic [7:0]  checksum;
    logic        accept;
    logic [15:0] len_next;
    logic [15:0] last_index;

    assign accept     = rx_valid && rx_ready;
    assign len_next   = {word_count[15:8], rx_data};
    assign last_index = word_count - 16'd1;

    assign rx_ready   = (state != ST_WRITE);
    assign imem_we    = (state == ST_WRITE);
    assign cpu_enable = (state == ST_DONE);
    assign load_done  = (state == ST_DONE);
    assign load_error = (state == ST_ERROR);
    assign fsm_state  = state;

    // imem_addr/imem_wdata are loaded only on entry to WRITE so they never move while imem_we is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            word_count <= '0;
            word_index <= '0;
            data_hi    <= '0;
            checksum   <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (accept && rx_data == START_BYTE) begin
                        state      <= ST_LEN_HI;
                        word_index <= '0;
                        checksum   <= '0;
                    end
                end
                ST_LEN_HI: begin
                    if (accept) begin
                        word_count <= {rx_data, 8'h00};
                        state      <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (accept) begin
                        word_count <= len_next;
                        if (len_next == 16'd0 || len_next > MAX_COUNT) state <= ST_ERROR;
                        else                                          state <= ST_DATA_HI;
                    end
                end
                ST_DATA_HI: begin
                    if (accept) begin
                        data_hi  <= rx_data;
                        checksum <= checksum ^ rx_data;
                        state    <= ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    if (accept) begin
                        imem_wdata <= {data_hi, rx_data};
                        imem_addr  <= word_index;
                        checksum   <= checksum ^ rx_data;
                        state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // The index stops at count-1, so a full 4096-word image ends at 12'hFFF without wrapping.
                    if ({4'd0, word_index} == last_index) begin
                        state <= ST_CHECK;
                    end else begin
                        word_index <= word_index + 12'd1;
                        state      <= ST_DATA_HI;
                    end
                end
                ST_CHECK: begin
                    if (accept) state <= (rx_data == checksum) ? ST_DONE : ST_ERROR;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of whole frames with expected end status, plus hand-written
// sequences for reload, mid-frame reset and the full-depth image; writes go through a scoreboard.
module tb_program_loader;
    import program_loader_pkg::*;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_enable;
    logic        load_done;
    logic        load_error;
    logic [3:0]  fsm_state;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [27:0] exp_q[$];
    logic [27:0] prev_wr;
    logic        prev_ok = 1'b0;

    program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_enable (cpu_enable),
        .load_done  (load_done),
        .load_error (load_error),
        .fsm_state  (fsm_state)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard/monitor: every write must match the head of exp_q; rx_ready must be the
    // complement of imem_we; address/data must hold while no write is in progress.
    always @(negedge clk) begin
        if (reset) begin
            prev_ok = 1'b0;
        end else begin
            total_cnt++;
            if (rx_ready === imem_we)
                $display("FAIL ready_vs_we: rx_ready=%0b imem_we=%0b", rx_ready, imem_we);
            else
                pass_cnt++;
            if (imem_we) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: addr=%0h data=%0h expected no write", imem_addr, imem_wdata);
                end else begin
                    logic [27:0] e;
                    e = exp_q.pop_front();
                    if ({imem_addr, imem_wdata} === e) pass_cnt++;
                    else $display("FAIL write: got %0h:%0h expected %0h:%0h", imem_addr, imem_wdata, e[27:16], e[15:0]);
                end
            end else if (prev_ok) begin
                total_cnt++;
                if ({imem_addr, imem_wdata} === prev_wr) pass_cnt++;
                else $display("FAIL addr_data_stable: got %0h expected %0h", {imem_addr, imem_wdata}, prev_wr);
            end
            prev_wr = {imem_addr, imem_wdata};
            prev_ok = 1'b1;
        end
    end

    // driver tasks: called at a falling edge, return at the falling edge after the byte is taken
    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (!rx_ready) begin
            total_cnt++;
            $display("FAIL ready_timeout: rx_ready=0 expected 1 within 8 cycles");
        end
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        rx_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_status(input string name, input logic done, input logic err);
        check({name, "_load_done"}, {31'd0, load_done}, {31'd0, done});
        check({name, "_cpu_enable"}, {31'd0, cpu_enable}, {31'd0, done});
        check({name, "_load_error"}, {31'd0, load_error}, {31'd0, err});
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    typedef struct {
        string       name;
        int          nbytes;
        logic [63:0] bytes;     // byte 0 in bits 63:56
        int          data_ofs;  // index of first data byte in the vector
        int          nwrites;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [7:0] vbyte(input logic [63:0] v, input int i);
        return v[63 - 8*i -: 8];
    endfunction

    initial begin
        logic [7:0]  cs;
        logic [15:0] w;

        vecs[0] = '{"good2",     8, 64'hA5_00_02_12_34_AB_CD_40, 3, 2, 1'b1, 1'b0};
        vecs[1] = '{"badsum",    8, 64'hA5_00_02_12_34_AB_CD_41, 3, 2, 1'b0, 1'b1};
        vecs[2] = '{"len0",      3, 64'hA5_00_00_00_00_00_00_00, 3, 0, 1'b0, 1'b1};
        vecs[3] = '{"len4097",   3, 64'hA5_10_01_00_00_00_00_00, 3, 0, 1'b0, 1'b1};
        vecs[4] = '{"junk_lead", 7, 64'h3C_A5_00_01_FF_EE_11_00, 4, 1, 1'b1, 1'b0};
        vecs[5] = '{"zero_word", 6, 64'hA5_00_01_00_00_00_00_00, 3, 1, 1'b1, 1'b0};

        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr", {20'd0, imem_addr}, 32'd0);
        check("rst_imem_wdata", {16'd0, imem_wdata}, 32'd0);
        check("rst_fsm_state", {28'd0, fsm_state}, {28'd0, ST_IDLE});
        check_status("rst", 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Table frames, rx_valid held high across each whole frame
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < vecs[v].nwrites; k++)
                exp_q.push_back({12'(k), vbyte(vecs[v].bytes, vecs[v].data_ofs + 2*k),
                                 vbyte(vecs[v].bytes, vecs[v].data_ofs + 2*k + 1)});
            for (int i = 0; i < vecs[v].nbytes; i++)
                send_byte(vbyte(vecs[v].bytes, i));
            idle_cycles(2);
            check_status(vecs[v].name, vecs[v].exp_done, vecs[v].exp_err);
        end

        // Reload from DONE, then reset while word 3 is half received
        send_byte(START_BYTE);
        check("reload_cpu_enable_drop", {31'd0, cpu_enable}, 32'd0);
        check("reload_load_done_drop", {31'd0, load_done}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h05);
        for (int k = 0; k < 3; k++) begin
            w = 16'h1111 * 16'(k + 1);
            exp_q.push_back({12'(k), w});
            send_byte(w[15:8]);
            send_byte(w[7:0]);
            check("we_one_cycle_after_lo", {31'd0, imem_we}, 32'd1);
        end
        send_byte(8'h44);
        rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midrst_fsm_state", {28'd0, fsm_state}, {28'd0, ST_IDLE});
        check("midrst_imem_addr", {20'd0, imem_addr}, 32'd0);
        check("midrst_imem_wdata", {16'd0, imem_wdata}, 32'd0);
        check("midrst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check_status("midrst", 1'b0, 1'b0);
        idle_cycles(4);
        exp_q.push_back({12'h000, 16'hBEEF});
        send_byte(START_BYTE);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hBE);
        send_byte(8'hEF);
        send_byte(8'hBE ^ 8'hEF);
        idle_cycles(2);
        check_status("after_rst_frame", 1'b1, 1'b0);

        // Full-depth image with random contents
        cs = 8'h00;
        send_byte(START_BYTE);
        send_byte(8'h10);
        send_byte(8'h00);
        for (int k = 0; k < MAX_WORDS; k++) begin
            w = 16'($urandom_range(0, 65535));
            exp_q.push_back({12'(k), w});
            cs = cs ^ w[15:8] ^ w[7:0];
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        send_byte(cs);
        idle_cycles(2);
        check("full_last_addr", {20'd0, imem_addr}, 32'h0000_0FFF);
        check_status("full", 1'b1, 1'b0);
        send_byte(START_BYTE);
        check("full_reload_cpu_drop", {31'd0, cpu_enable}, 32'd0);
        check("full_reload_done_drop", {31'd0, load_done}, 32'd0);
        idle_cycles(2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: one clock; reset is synchronous and active-high.
REQ-002 SHALL provide port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL provide port: reset  input  1  synchronous active-high reset.
REQ-004 SHALL provide port: rx_valid  input  1  byte available on rx_data.
REQ-005 SHALL provide port: rx_data  input  8  incoming load-stream byte.
REQ-006 SHALL provide port: rx_ready  output  1  loader accepts byte this cycle.
REQ-007 SHALL provide port: imem_we  output  1  instruction-memory write strobe.
REQ-008 SHALL provide port: imem_addr  output  12  instruction-memory word address.
REQ-009 SHALL provide port: imem_wdata  output  16  instruction word to write.
REQ-010 SHALL provide port: cpu_enable  output  1  pipeline enable; high only after a verified load.
REQ-011 SHALL provide port: load_done  output  1  level, verified image resident.
REQ-012 SHALL provide port: load_error  output  1  level, last load aborted.
REQ-013 SHALL use constant START_BYTE, default 8'hA5, meaning frame start marker.
REQ-014 SHALL use constant MAX_WORDS, default 4096, meaning instruction-memory depth.

Function
REQ-015 SHALL accept a byte only when rx_valid && rx_ready in the same cycle.
REQ-016 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, DONE, ERROR.
REQ-017 SHALL, in IDLE, DONE and ERROR, go to LEN_HI on an accepted START_BYTE and ignore any other byte.
REQ-018 SHALL capture the word count big-endian: LEN_HI captures bits 15:8, LEN_LO captures bits 7:0.
REQ-019 SHALL go from LEN_LO to ERROR if the count is 0 or greater than MAX_WORDS, else to DATA_HI.
REQ-020 SHALL capture the instruction high byte in DATA_HI and low byte in DATA_LO, then go to WRITE.
REQ-021 SHALL, in WRITE, assert imem_we for exactly one cycle with imem_addr = current word index and imem_wdata = assembled word.
REQ-022 SHALL therefore pulse imem_we exactly 1 cycle after the low byte is accepted.
REQ-023 SHALL drive rx_ready low in WRITE and high in all other states.
REQ-024 SHALL, after WRITE, increment the word index and go to DATA_HI if words remain, else to CHECK.
REQ-025 SHALL end on index = count-1, so MAX_WORDS words end at address 12'hFFF with no wrap.
REQ-026 SHALL maintain an 8-bit checksum: the XOR of all data bytes only, excluding start and length bytes.
REQ-027 SHALL compare the checksum with the byte accepted in CHECK; go to DONE on match, else to ERROR.
REQ-028 SHALL assert cpu_enable and load_done only in DONE, and load_error only in ERROR.
REQ-029 SHALL drop cpu_enable and load_done in the cycle after a START_BYTE is accepted in DONE, which begins a reload.
REQ-030 SHALL clear the word index and checksum on every transition into LEN_HI.
REQ-031 SHALL hold imem_we low in every state except WRITE.
REQ-032 SHALL keep imem_addr and imem_wdata stable while imem_we is low.

Reset
REQ-033 SHALL, when reset is high at a clock edge, enter IDLE from any state, including mid-frame.
REQ-034 SHALL, on that reset, drive imem_we=0, imem_addr=0, imem_wdata=0, cpu_enable=0, load_done=0, load_error=0 and rx_ready=1.
REQ-035 SHALL, on that reset, clear the word count, word index and checksum.
REQ-036 SHALL NOT issue a partial write after a reset.

Structure
REQ-037 SHALL place the state enum, START_BYTE and MAX_WORDS in the shared CPU package.
REQ-038 SHALL be a single module with no sub-module; the FSM, counters and checksum are all local.

Verification
REQ-039 SHALL cover: A5,00,02,12,34,AB,CD,(12^34^AB^CD=40) -> writes 0x000<-1234 and 0x001<-ABCD, then DONE with cpu_enable=1.
REQ-040 SHALL cover: the same frame with checksum 41 -> two writes occur, then ERROR with load_error=1 and cpu_enable=0.
REQ-041 SHALL cover: A5,00,00 and A5,10,01 -> ERROR with no imem_we pulse.
REQ-042 SHALL cover: rx_valid held high continuously -> rx_ready low exactly in each WRITE cycle, with no byte lost or duplicated.
REQ-043 SHALL cover: reset asserted after DATA_HI of word 3 -> IDLE, no write for word 3, then a fresh frame loads from address 0.
REQ-044 SHALL cover: a 4096-word frame -> the last write goes to 0xFFF, then a new A5 in DONE drops cpu_enable the next cycle.
